// File: rtl/clock_pkg.sv
// Shared clock definitions: mode codes, digit positions and
// seven-segment encodings used by the display and mode logic.
package clock_pkg;

   typedef enum logic [2:0] {
      MODE_CLOCK     = 3'd0,
      MODE_AL_HOUR   = 3'd1,
      MODE_AL_MIN    = 3'd2,
      MODE_STOPWATCH = 3'd3,
      MODE_SET_HOUR  = 3'd4,
      MODE_SET_MIN   = 3'd5
   } mode_t;

   localparam logic [2:0] DIG_S1  = 3'd0;
   localparam logic [2:0] DIG_S10 = 3'd1;
   localparam logic [2:0] DIG_M1  = 3'd2;
   localparam logic [2:0] DIG_M10 = 3'd3;
   localparam logic [2:0] DIG_H1  = 3'd4;
   localparam logic [2:0] DIG_H10 = 3'd5;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // segments {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      unique case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Combinational 6-bit binary to two BCD digits, with an
// out-of-range flag (limit 23 for hours, 59 otherwise).
module bin2bcd6
   import clock_pkg::*;
(
   input  logic [5:0] val,
   input  logic       hour,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       bad
);

   always_comb begin
      tens = 4'd0;
      ones = 4'(val);
      for (int i = 1; i <= 6; i++) begin
         if (val >= 6'(10 * i)) begin
            tens = 4'(i);
            ones = 4'(val - 6'(10 * i));
         end
      end
   end

   assign bad = hour ? (val > 6'd23) : (val > 6'd59);

endmodule

// File: rtl/display_mux.sv
// Six-digit multiplexed time display with per-frame shadowing,
// out-of-range dashes, adjust-mode blinking and separator dots.
module display_mux
   import clock_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] h,
   input  logic [5:0] m,
   input  logic [5:0] s,
   input  logic [2:0] mode,
   input  logic       alarmeon,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       dp
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0] pre;
   logic [2:0]    idx;
   logic [FW-1:0] fcnt;
   logic          phase;
   logic [5:0]    sh_h, sh_m, sh_s;
   logic [2:0]    sh_mode;
   logic          sh_al;

   logic          tick, fwrap;
   logic [5:0]    val;
   logic          hour, bad, blank;
   logic [3:0]    tens, ones;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   assign tick  = (pre == PW'(SCAN_DIV - 1));
   assign fwrap = (fcnt == FW'(BLINK_FRAMES - 1));

   // shadows only reload at the frame boundary so a frame never tears
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre     <= '0;
         idx     <= DIG_S1;
         fcnt    <= '0;
         phase   <= 1'b0;
         sh_h    <= '0;
         sh_m    <= '0;
         sh_s    <= '0;
         sh_mode <= '0;
         sh_al   <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            if (idx == DIG_H10) begin
               idx     <= DIG_S1;
               sh_h    <= h;
               sh_m    <= m;
               sh_s    <= s;
               sh_mode <= mode;
               sh_al   <= alarmeon;
               if (fwrap) begin
                  fcnt  <= '0;
                  phase <= ~phase;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

   always_comb begin
      val  = sh_s;
      hour = 1'b0;
      unique case (1'b1)
         (idx == DIG_H1 || idx == DIG_H10): begin
            val  = sh_h;
            hour = 1'b1;
         end
         (idx == DIG_M1 || idx == DIG_M10): val = sh_m;
         default: ;
      endcase
   end

   bin2bcd6 u_bcd (
      .val  (val),
      .hour (hour),
      .tens (tens),
      .ones (ones),
      .bad  (bad)
   );

   always_comb begin
      blank = 1'b0;
      if (phase) begin
         unique case (1'b1)
            (sh_mode == MODE_AL_HOUR || sh_mode == MODE_SET_HOUR):
               blank = (idx == DIG_H1 || idx == DIG_H10);
            (sh_mode == MODE_AL_MIN || sh_mode == MODE_SET_MIN):
               blank = (idx == DIG_M1 || idx == DIG_M10);
            default: ;
         endcase
      end
      seg_nxt = bad ? SEG_DASH : seg_of(idx[0] ? tens : ones);
      if (blank) seg_nxt = SEG_BLANK;
      dp_nxt = !(idx == DIG_M1 || idx == DIG_H1 ||
                 (idx == DIG_S1 && sh_al));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(6'b1 << idx);
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: frame-level reference model
// driven by directed and random time/mode stimulus.
module tb_display_mux;

   localparam int D  = 4;
   localparam int BF = 2;
   localparam int FR = 6 * D;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] h = '0, m = '0, s = '0;
   logic [2:0] mode = '0;
   logic       alarmeon = 1'b0;
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;

   display_mux #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
      .clk      (clk),
      .rst      (rst),
      .h        (h),
      .m        (m),
      .s        (s),
      .mode     (mode),
      .alarmeon (alarmeon),
      .seg      (seg),
      .an       (an),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] TAB [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   int checks = 0;
   int failures = 0;
   int k = 0;
   int last_d = 0;
   int md_h = 0, md_m = 0, md_s = 0, md_mode = 0, md_al = 0;

   task automatic check_out(string tag, logic [5:0] ea,
                            logic [6:0] es, logic ed);
      checks++;
      assert (an === ea) else begin
         failures++;
         $error("FAIL %s an k=%0d got %b exp %b", tag, k, an, ea);
      end
      checks++;
      assert (seg === es) else begin
         failures++;
         $error("FAIL %s seg k=%0d got %b exp %b", tag, k, seg, es);
      end
      checks++;
      assert (dp === ed) else begin
         failures++;
         $error("FAIL %s dp k=%0d got %b exp %b", tag, k, dp, ed);
      end
   endtask

   // k counts edges since reset release; outputs after edge k show
   // digit (k/D)%6 of the time latched at the start of frame k/FR
   task automatic step();
      int d, v, lim, ph, mo;
      logic [6:0] es;
      logic ed;
      @(posedge clk);
      d  = (k / D) % 6;
      ph = ((k / FR) / BF) % 2;
      v  = (d < 2) ? md_s : (d < 4) ? md_m : md_h;
      lim = (d < 4) ? 59 : 23;
      if (v > lim) es = 7'b0111111;
      else es = TAB[(d % 2 == 1) ? v / 10 : v % 10];
      mo = md_mode;
      if (ph == 1 && d >= 4 && (mo == 1 || mo == 4)) es = 7'b1111111;
      if (ph == 1 && (d == 2 || d == 3) && (mo == 2 || mo == 5))
         es = 7'b1111111;
      ed = !(d == 2 || d == 4 || (d == 0 && md_al == 1));
      #1;
      check_out("scan", ~(6'b1 << d), es, ed);
      last_d = d;
      if ((k + 1) % FR == 0) begin
         md_h = int'(h); md_m = int'(m); md_s = int'(s);
         md_mode = int'(mode); md_al = int'(alarmeon);
      end
      k++;
   endtask

   task automatic frames(int n);
      repeat (n * FR) step();
   endtask

   task automatic model_reset();
      k = 0;
      md_h = 0; md_m = 0; md_s = 0; md_mode = 0; md_al = 0;
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 check_out("rst_async", 6'b111111, 7'b1111111, 1'b1);
      repeat (2) @(posedge clk);
      #1 check_out("rst_hold", 6'b111111, 7'b1111111, 1'b1);

      h = 6'd12; m = 6'd34; s = 6'd56; mode = 3'd0;
      @(negedge clk) rst = 1'b1;
      model_reset();
      frames(2);

      repeat (FR / 2) step();
      s = 6'd57;
      repeat (FR / 2) step();
      frames(1);

      h = 6'd30; m = 6'd60;
      frames(2);

      h = 6'd12; m = 6'd34; mode = 3'd4;
      frames(8);
      mode = 3'd3;
      frames(4);
      mode = 3'd1; frames(4);
      mode = 3'd2; frames(4);
      mode = 3'd5; frames(4);

      alarmeon = 1'b1; mode = 3'd7;
      frames(4);

      repeat (150) begin
         h = 6'($urandom_range(0, 31));
         m = 6'($urandom_range(0, 63));
         s = 6'($urandom_range(0, 63));
         mode = 3'($urandom_range(0, 7));
         alarmeon = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 40)) step();
      end

      h = 6'd9; m = 6'd8; s = 6'd7; mode = 3'd0;
      frames(2);
      for (int i = 0; i < FR; i++) begin
         step();
         if (last_d == 3) break;
      end
      checks++;
      assert (last_d == 3) else begin
         failures++;
         $error("FAIL mid_rst_reach got %0d exp 3", last_d);
      end
      #2 rst = 1'b0;
      #1 check_out("mid_rst", 6'b111111, 7'b1111111, 1'b1);
      @(posedge clk);
      #1 check_out("mid_rst_hold", 6'b111111, 7'b1111111, 1'b1);
      @(negedge clk) rst = 1'b1;
      model_reset();
      step();
      checks++;
      assert (an === 6'b111110 && seg === 7'b1000000) else begin
         failures++;
         $error("FAIL post_rst got an=%b seg=%b exp an=111110 seg=1000000",
                an, seg);
      end
      frames(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000; the number of clk cycles each digit is shown, minimum 2.
REQ-002 SHALL have parameter BLINK_FRAMES, default 32; the number of full 6-digit scan frames per blink half-period, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit; the system clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port h, input, 6 bits; binary hours, 0..23 valid.
REQ-006 SHALL have port m, input, 6 bits; binary minutes, 0..59 valid.
REQ-007 SHALL have port s, input, 6 bits; binary seconds, 0..59 valid.
REQ-008 SHALL have port mode, input, 3 bits; the current mode code: 0 clock, 1 alarm-hour adjust, 2 alarm-minute adjust, 3 stopwatch, 4 hour adjust, 5 minute adjust.
REQ-009 SHALL have port alarmeon, input, 1 bit; the alarm-armed indicator.
REQ-010 SHALL have port seg, output, 7 bits; the segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port an, output, 6 bits; the digit enables, active-low, one-hot when active.
REQ-012 SHALL have port dp, output, 1 bit; the decimal point, active-low.

Function
REQ-013 SHALL run a prescaler 0..SCAN_DIV-1 that wraps to 0 and asserts an internal tick for one cycle at SCAN_DIV-1.
REQ-014 SHALL advance a digit index 0..5 on each tick, with 5 wrapping to 0; a wrap from 5 to 0 completes one frame.
REQ-015 SHALL map the digit index as follows: 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens, 4 = hours ones, 5 = hours tens.
REQ-016 SHALL capture h, m, s, mode and alarmeon into shadow registers only on the tick that wraps the index from 5 to 0, so that each frame shows one consistent time with no tearing.
REQ-017 SHALL convert each shadow value into tens and ones BCD digits; a seconds or minutes value above 59, or an hours value above 23, SHALL display as dash on both of its digits.
REQ-018 SHALL use these seg encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
REQ-019 SHALL register an, seg and dp, so that they update exactly one clk cycle after the digit index changes.
REQ-020 SHALL drive an with bit[index] low and all other bits high.
REQ-021 SHALL count frames in a counter 0..BLINK_FRAMES-1 and toggle a blink phase on each wrap of that counter; the phase SHALL be 0 after reset.
REQ-022 SHALL blank digits 4 and 5 when the phase is 1 and the shadow mode is 1 or 4, and SHALL blank digits 2 and 3 when the phase is 1 and the shadow mode is 2 or 5.
REQ-023 SHALL NOT blank any digit in modes 0 and 3.
REQ-024 SHALL treat a shadow mode of 6 or 7 as mode 0.
REQ-025 SHALL drive dp low on digits 2 and 4, acting as separators, and low on digit 0 only when the shadow alarmeon is 1; dp SHALL be high otherwise.
REQ-026 SHALL show dp on a blanked digit as specified in REQ-025; blanking SHALL affect seg only.

Reset
REQ-027 SHALL, while rst is low, clear the prescaler, digit index, frame counter, blink phase and all shadow registers to 0.
REQ-028 SHALL, while rst is low, drive an=111111, seg=1111111 and dp=1.
REQ-029 SHALL, on rst asserted mid-frame, blank the outputs immediately; after rst releases, the first tick SHALL select digit 1.
REQ-030 SHALL drive an=111110 on the first clk edge after rst releases, showing the shadow value 0 (seg=1000000).

Structure
REQ-031 SHALL take the mode codes, the seg encoding constants and the digit index constants from a shared clock package, which the mode FSM also uses.
REQ-032 SHALL contain exactly one sub-module, bin2bcd6: a combinational 6-bit-to-BCD converter (tens, ones) with an out-of-range flag input by limit (23 or 59).
REQ-033 SHALL keep all sequential logic in display_mux.

Verification
REQ-034 Bench SHALL cover: SCAN_DIV=4, h=12, m=34, s=56, mode=0 held for 2 frames -> second frame an cycles 111110..011111, each held 4 cycles, with seg digits 6,5,4,3,2,1 and dp low on digits 2 and 4.
REQ-035 Bench SHALL cover: s changes from 56 to 57 mid-frame -> the current frame still shows 6; the next frame shows 7 on digit 0.
REQ-036 Bench SHALL cover: h=30, m=60 -> digits 2..5 show seg=0111111; digits 0 and 1 remain valid.
REQ-037 Bench SHALL cover: BLINK_FRAMES=2, mode=4 for 8 frames -> digits 4 and 5 show seg=1111111 in frames 2-3 and 6-7 and show the value otherwise; digits 0..3 are never blank; mode=3 -> no blanking.
REQ-038 Bench SHALL cover: alarmeon=1, mode=7 -> dp low on digit 0 and blinking behaves as mode 0 (none).
REQ-039 Bench SHALL cover: rst pulsed low while digit 3 is active -> an=111111, seg=1111111, dp=1 asynchronously; after release, an=111110 and the shadow shows 0.
